// File: rtl/fast_fifo_read_adapter_pkg.sv
// -----------------------------------------------------------------------------
// dedekind_fifo_pkg
//   Constants shared by the FastFIFO family and a constant-evaluable clog2
//   helper used to size counters.
//   Ports: none (package).
//   Optional feature macro used by importers: FAST_FIFO_READ_ADAPTER_STATS_EN.
// -----------------------------------------------------------------------------
package dedekind_fifo_pkg;

  localparam int FASTFIFO_READ_LATENCY = 3;
  localparam int FASTFIFO_DEPTH_LOG2   = 5;

  // Bits needed to hold values 0..value-1; never returns less than 1 so the
  // result can always size a vector.
  function automatic int clog2(input int value);
    int bits;
    bits = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        bits = i + 1;
      end
    end
    return bits;
  endfunction

endpackage

// File: rtl/fast_fifo_read_adapter_if.sv
// -----------------------------------------------------------------------------
// fast_fifo_read_adapter_if
//   Bundles the FastFIFO read port and the downstream valid/ready stream of
//   the read adapter.
//   Signals:
//     fifoReadEnable  adapter -> FastFIFO readEnable
//     fifoEmpty       FastFIFO empty
//     fifoDataOut     FastFIFO dataOut (WIDTH)
//     fifoDataValid   FastFIFO dataOutValid
//     outData         stream data, head of the skid buffer (WIDTH)
//     outValid        stream valid
//     outReady        stream ready from the consumer
//     overflowError   sticky error flag
//   Modports: master = adapter side, slave = FastFIFO/consumer side.
// -----------------------------------------------------------------------------
interface fast_fifo_read_adapter_if #(
  parameter int WIDTH = 20
);

  logic             fifoReadEnable;
  logic             fifoEmpty;
  logic [WIDTH-1:0] fifoDataOut;
  logic             fifoDataValid;
  logic [WIDTH-1:0] outData;
  logic             outValid;
  logic             outReady;
  logic             overflowError;

  modport master (
    output fifoReadEnable,
    input  fifoEmpty,
    input  fifoDataOut,
    input  fifoDataValid,
    output outData,
    output outValid,
    input  outReady,
    output overflowError
  );

  modport slave (
    input  fifoReadEnable,
    output fifoEmpty,
    output fifoDataOut,
    output fifoDataValid,
    input  outData,
    input  outValid,
    output outReady,
    input  overflowError
  );

endinterface

// File: rtl/fast_fifo_read_adapter_skid_buffer_mem.sv
// -----------------------------------------------------------------------------
// skid_buffer_mem
//   2**DEPTH_LOG2 x WIDTH register array backing the adapter's skid buffer.
//   Storage has no reset; validity is tracked by the adapter's occupancy.
//   Ports:
//     clk     clock
//     we      write enable
//     wrAddr  write address (DEPTH_LOG2)
//     wrData  write data (WIDTH)
//     rdAddr  read address (DEPTH_LOG2), asynchronous read
//     rdData  read data (WIDTH)
// -----------------------------------------------------------------------------
module skid_buffer_mem #(
  parameter int WIDTH      = 20,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] wrAddr,
  input  logic [WIDTH-1:0]      wrData,
  input  logic [DEPTH_LOG2-1:0] rdAddr,
  output logic [WIDTH-1:0]      rdData
);

  logic [WIDTH-1:0] mem_r [0:(1 << DEPTH_LOG2)-1];

  // Storage write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[wrAddr] <= wrData;
    end
  end

  assign rdData = mem_r[rdAddr];

endmodule

// File: rtl/fast_fifo_read_adapter.sv
// -----------------------------------------------------------------------------
// fast_fifo_read_adapter
//   Drains a FastFIFO (fixed READ_LATENCY read latency, dataOutValid strobe)
//   into a show-ahead valid/ready stream. Reads are only issued when the skid
//   buffer has room for every word already requested, so the stream may stall
//   freely while still sustaining one word per cycle with outReady high.
//   Ports:
//     clk, rst     clock and synchronous active-high reset
//     bus          fast_fifo_read_adapter_if.master (FastFIFO port + stream)
//     wordCount    [31:0] pops, wrapping       (FAST_FIFO_READ_ADAPTER_STATS_EN)
//     stallCount   [31:0] stalled cycles, sat. (FAST_FIFO_READ_ADAPTER_STATS_EN)
//   Optional feature macro: FAST_FIFO_READ_ADAPTER_STATS_EN.
// -----------------------------------------------------------------------------
module fast_fifo_read_adapter
  import dedekind_fifo_pkg::*;
#(
  parameter int WIDTH           = 20,
  parameter int READ_LATENCY    = FASTFIFO_READ_LATENCY,
  parameter int SKID_DEPTH_LOG2 = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  fast_fifo_read_adapter_if.master bus
`ifdef FAST_FIFO_READ_ADAPTER_STATS_EN
  ,
  output logic [31:0]              wordCount,
  output logic [31:0]              stallCount
`endif
);

  localparam int CAPACITY = 1 << SKID_DEPTH_LOG2;
  localparam int CNT_W    = SKID_DEPTH_LOG2 + 1;
  localparam int SUM_W    = CNT_W + 1;
  localparam int DRAIN_W  = clog2(READ_LATENCY + 1);

  localparam logic [CNT_W-1:0]   CAP_CNT    = CNT_W'(CAPACITY);
  localparam logic [SUM_W-1:0]   CAP_SUM    = SUM_W'(CAPACITY);
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(READ_LATENCY);

  // A full pipeline of returns plus one word being popped must fit.
  if (CAPACITY < READ_LATENCY + 2) begin : g_capacity_check
    $error("skid capacity 2**SKID_DEPTH_LOG2 must be at least READ_LATENCY+2");
  end

  logic [CNT_W-1:0]           occupancy_r;
  logic [CNT_W-1:0]           in_flight_r;
  logic [SKID_DEPTH_LOG2-1:0] wr_ptr_r;
  logic [SKID_DEPTH_LOG2-1:0] rd_ptr_r;
  logic [DRAIN_W-1:0]         drain_cnt_r;
  logic                       overflow_r;

  logic [CNT_W-1:0]           occupancy_nxt_s;
  logic [CNT_W-1:0]           in_flight_nxt_s;
  logic [SUM_W-1:0]           committed_s;
  logic                       drain_active_s;
  logic                       has_credit_s;
  logic                       issue_s;
  logic                       accept_s;
  logic                       full_s;
  logic                       push_s;
  logic                       pop_s;
  logic                       ret_s;
  logic                       err_s;
  logic                       out_valid_s;
  logic [WIDTH-1:0]           rd_data_s;

  // Credit is taken from registered counts only, so a pop this cycle frees
  // space for issue only from the next cycle on.
  assign committed_s    = {1'b0, occupancy_r} + {1'b0, in_flight_r};
  assign has_credit_s   = (committed_s < CAP_SUM);
  assign drain_active_s = (drain_cnt_r != '0);
  assign issue_s        = !bus.fifoEmpty && has_credit_s && !drain_active_s && !rst;

  // Returns during the post-reset drain window are stale pipe contents.
  assign accept_s    = bus.fifoDataValid && !drain_active_s;
  assign full_s      = (occupancy_r == CAP_CNT);
  assign push_s      = accept_s && !full_s;
  assign ret_s       = accept_s && (in_flight_r != '0);
  assign err_s       = accept_s && (full_s || (in_flight_r == '0));
  assign out_valid_s = (occupancy_r != '0);
  assign pop_s       = out_valid_s && bus.outReady;

  // Next-state of the occupancy and in-flight counters
  always_comb begin
    occupancy_nxt_s = occupancy_r;
    in_flight_nxt_s = in_flight_r;
    case ({push_s, pop_s})
      2'b10:   occupancy_nxt_s = occupancy_r + CNT_W'(1);
      2'b01:   occupancy_nxt_s = occupancy_r - CNT_W'(1);
      default: occupancy_nxt_s = occupancy_r;
    endcase
    case ({issue_s, ret_s})
      2'b10:   in_flight_nxt_s = in_flight_r + CNT_W'(1);
      2'b01:   in_flight_nxt_s = in_flight_r - CNT_W'(1);
      default: in_flight_nxt_s = in_flight_r;
    endcase
  end

  // Counters, pointers, drain window and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      occupancy_r <= '0;
      in_flight_r <= '0;
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      drain_cnt_r <= DRAIN_LOAD;
      overflow_r  <= 1'b0;
    end else begin
      occupancy_r <= occupancy_nxt_s;
      in_flight_r <= in_flight_nxt_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + SKID_DEPTH_LOG2'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + SKID_DEPTH_LOG2'(1);
      end
      if (drain_active_s) begin
        drain_cnt_r <= drain_cnt_r - DRAIN_W'(1);
      end
      if (err_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  skid_buffer_mem #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (SKID_DEPTH_LOG2)
  ) u_mem (
    .clk    (clk),
    .we     (push_s),
    .wrAddr (wr_ptr_r),
    .wrData (bus.fifoDataOut),
    .rdAddr (rd_ptr_r),
    .rdData (rd_data_s)
  );

  assign bus.fifoReadEnable = issue_s;
  assign bus.outValid       = out_valid_s;
  assign bus.outData        = rd_data_s;
  assign bus.overflowError  = overflow_r;

`ifdef FAST_FIFO_READ_ADAPTER_STATS_EN
  logic [31:0] word_count_r;
  logic [31:0] stall_count_r;

  // Pop counter wraps; stall counter saturates
  always_ff @(posedge clk) begin
    if (rst) begin
      word_count_r  <= 32'd0;
      stall_count_r <= 32'd0;
    end else begin
      if (pop_s) begin
        word_count_r <= word_count_r + 32'd1;
      end
      if (out_valid_s && !bus.outReady && (stall_count_r != 32'hFFFF_FFFF)) begin
        stall_count_r <= stall_count_r + 32'd1;
      end
    end
  end

  assign wordCount  = word_count_r;
  assign stallCount = stall_count_r;
`endif

endmodule

// File: tb/tb_fast_fifo_read_adapter.sv
// -----------------------------------------------------------------------------
// tb_fast_fifo_read_adapter
//   Directed bench: a behavioural FastFIFO (ring of words plus a 3-stage
//   valid/data pipe that is never reset) feeds the adapter; a negedge monitor
//   logs issues and stream pops with their cycle numbers.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fast_fifo_read_adapter;

  localparam int WIDTH = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fast_fifo_read_adapter_if #(.WIDTH(WIDTH)) bus();

`ifdef FAST_FIFO_READ_ADAPTER_STATS_EN
  logic [31:0] word_count;
  logic [31:0] stall_count;
`endif

  fast_fifo_read_adapter #(
    .WIDTH           (WIDTH),
    .READ_LATENCY    (3),
    .SKID_DEPTH_LOG2 (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus)
`ifdef FAST_FIFO_READ_ADAPTER_STATS_EN
    ,
    .wordCount  (word_count),
    .stallCount (stall_count)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- upstream FastFIFO model ----------------
  logic [WIDTH-1:0] up_mem [0:255];
  logic [7:0]       up_wr = 8'd0;
  logic [7:0]       up_rd = 8'd0;
  logic             v1 = 1'b0, v2 = 1'b0, v3 = 1'b0;
  logic [WIDTH-1:0] d1 = '0, d2 = '0, d3 = '0;
  logic             force_valid = 1'b0;
  logic             fifo_empty = 1'b1;

  assign bus.fifoDataValid = v3 | force_valid;
  assign bus.fifoDataOut   = d3;
  assign bus.fifoEmpty     = fifo_empty;

  always @(posedge clk) begin
    v1 <= bus.fifoReadEnable && (up_rd != up_wr);
    d1 <= up_mem[up_rd];
    v2 <= v1; d2 <= d1;
    v3 <= v2; d3 <= d2;
    if (rst) up_rd <= up_wr;
    else if (bus.fifoReadEnable && (up_rd != up_wr)) up_rd <= up_rd + 8'd1;
  end

  always begin
    @(posedge clk);
    #1;
    fifo_empty = (up_rd == up_wr);
  end

  // ---------------- monitor ----------------
  int               cyc = 0;
  int               issue_cnt = 0;
  int               rx_cnt = 0;
  int               issue_cyc [0:255];
  int               rx_cyc [0:255];
  logic [WIDTH-1:0] rx_data [0:255];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.fifoReadEnable) begin
      issue_cyc[issue_cnt % 256] <= cyc;
      issue_cnt <= issue_cnt + 1;
    end
    if (bus.outValid && bus.outReady) begin
      rx_data[rx_cnt % 256] <= bus.outData;
      rx_cyc[rx_cnt % 256]  <= cyc;
      rx_cnt <= rx_cnt + 1;
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [WIDTH-1:0] w);
    up_mem[up_wr] = w;
    up_wr = up_wr + 8'd1;
  endtask

  task automatic wait_rx(input int target, input string name);
    int c;
    c = 0;
    while (rx_cnt < target && c < 1000) begin
      @(posedge clk); #1;
      c++;
    end
    n_cmp++;
    if (rx_cnt < target) begin
      n_bad++;
      $display("FAIL %s_timeout: received %0d words, required %0d", name, rx_cnt, target);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    bus.outReady = 1'b0;
    wait_cycles(3);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.fifoReadEnable !== 1'b0) begin n_bad++; $display("FAIL reset_rden: cycle %0d got %b expected 0", i, bus.fifoReadEnable); end
      n_cmp++;
      if (bus.outValid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: cycle %0d got %b expected 0", i, bus.outValid); end
      n_cmp++;
      if (bus.overflowError !== 1'b0) begin n_bad++; $display("FAIL reset_err: cycle %0d got %b expected 0", i, bus.overflowError); end
    end
    n_cmp++;
    if (dut.occupancy_r !== 4'd0 || dut.in_flight_r !== 4'd0) begin
      n_bad++; $display("FAIL reset_counts: occ %0d inflight %0d expected 0 0", dut.occupancy_r, dut.in_flight_r);
    end
    wait_cycles(1);
  endtask

  task automatic test_stream;
    int ib, rb;
    ib = issue_cnt;
    rb = rx_cnt;
    bus.outReady = 1'b1;
    for (int i = 0; i < 16; i++) push_word(WIDTH'(i));
    wait_rx(rb + 16, "stream");
    wait_cycles(2);
    n_cmp++;
    if (rx_cyc[rb % 256] - issue_cyc[ib % 256] !== 4) begin
      n_bad++; $display("FAIL stream_latency: got %0d cycles expected 4", rx_cyc[rb % 256] - issue_cyc[ib % 256]);
    end
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (rx_data[(rb + i) % 256] !== WIDTH'(i)) begin
        n_bad++; $display("FAIL stream_data[%0d]: got %0h expected %0h", i, rx_data[(rb + i) % 256], i);
      end
    end
    n_cmp++;
    if (rx_cyc[(rb + 15) % 256] - rx_cyc[rb % 256] !== 15) begin
      n_bad++; $display("FAIL stream_gapless: span %0d expected 15", rx_cyc[(rb + 15) % 256] - rx_cyc[rb % 256]);
    end
    n_cmp++;
    if (issue_cnt - ib !== 16) begin n_bad++; $display("FAIL stream_issues: got %0d expected 16", issue_cnt - ib); end
    n_cmp++;
    if (dut.in_flight_r !== 4'd0) begin n_bad++; $display("FAIL stream_inflight: got %0d expected 0", dut.in_flight_r); end
  endtask

  task automatic test_backpressure;
    int ib, rb;
    bus.outReady = 1'b0;
    ib = issue_cnt;
    rb = rx_cnt;
    for (int i = 0; i < 16; i++) push_word(WIDTH'(100 + i));
    wait_cycles(20);
    @(negedge clk);
    n_cmp++;
    if (issue_cnt - ib !== 8) begin n_bad++; $display("FAIL bp_issues: got %0d expected 8", issue_cnt - ib); end
    n_cmp++;
    if (bus.fifoReadEnable !== 1'b0) begin n_bad++; $display("FAIL bp_rden: got %b expected 0", bus.fifoReadEnable); end
    n_cmp++;
    if (dut.occupancy_r !== 4'd8) begin n_bad++; $display("FAIL bp_occupancy: got %0d expected 8", dut.occupancy_r); end
    n_cmp++;
    if (bus.outValid !== 1'b1 || bus.outData !== WIDTH'(100)) begin
      n_bad++; $display("FAIL bp_head: valid %b data %0h expected 1 64", bus.outValid, bus.outData);
    end
    @(posedge clk); #1;
    bus.outReady = 1'b1;
    wait_rx(rb + 16, "bp");
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (rx_data[(rb + i) % 256] !== WIDTH'(100 + i)) begin
        n_bad++; $display("FAIL bp_data[%0d]: got %0h expected %0h", i, rx_data[(rb + i) % 256], 100 + i);
      end
    end
    n_cmp++;
    if (bus.overflowError !== 1'b0) begin n_bad++; $display("FAIL bp_err: got %b expected 0", bus.overflowError); end
  endtask

  task automatic test_toggle;
    logic [WIDTH-1:0] exp_w [0:99];
    logic [3:0]       max_occ;
    int               rb, c;
    rb = rx_cnt;
    max_occ = 4'd0;
    for (int i = 0; i < 100; i++) begin
      exp_w[i] = WIDTH'($urandom);
      push_word(exp_w[i]);
    end
    bus.outReady = 1'b1;
    c = 0;
    while (rx_cnt < rb + 100 && c < 1000) begin
      @(negedge clk);
      if (dut.occupancy_r > max_occ) max_occ = dut.occupancy_r;
      @(posedge clk); #1;
      bus.outReady = !bus.outReady;
      c++;
    end
    bus.outReady = 1'b1;
    n_cmp++;
    if (rx_cnt < rb + 100) begin n_bad++; $display("FAIL toggle_timeout: received %0d expected 100", rx_cnt - rb); end
    n_cmp++;
    if (max_occ > 4'd8) begin n_bad++; $display("FAIL toggle_maxocc: got %0d expected <= 8", max_occ); end
    for (int i = 0; i < 100; i++) begin
      n_cmp++;
      if (rx_data[(rb + i) % 256] !== exp_w[i]) begin
        n_bad++; $display("FAIL toggle_data[%0d]: got %0h expected %0h", i, rx_data[(rb + i) % 256], exp_w[i]);
      end
    end
    n_cmp++;
    if (bus.overflowError !== 1'b0) begin n_bad++; $display("FAIL toggle_err: got %b expected 0", bus.overflowError); end
    wait_cycles(4);
  endtask

  task automatic test_reset_midflight;
    int ib, rb, c;
    bus.outReady = 1'b0;
    ib = issue_cnt;
    for (int i = 0; i < 5; i++) push_word(WIDTH'(200 + i));
    c = 0;
    while (issue_cnt < ib + 3 && c < 50) begin
      @(posedge clk); #1;
      c++;
    end
    n_cmp++;
    if (dut.in_flight_r !== 4'd3) begin n_bad++; $display("FAIL mid_inflight: got %0d expected 3", dut.in_flight_r); end
    rst = 1'b1;
    wait_cycles(1);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.outValid !== 1'b0) begin n_bad++; $display("FAIL mid_valid: cycle %0d got %b expected 0", i, bus.outValid); end
      n_cmp++;
      if (bus.overflowError !== 1'b0) begin n_bad++; $display("FAIL mid_err: cycle %0d got %b expected 0", i, bus.overflowError); end
    end
    @(posedge clk); #1;
    rb = rx_cnt;
    bus.outReady = 1'b1;
    push_word(20'h5A5A5);
    wait_rx(rb + 1, "mid");
    n_cmp++;
    if (rx_data[rb % 256] !== 20'h5A5A5) begin
      n_bad++; $display("FAIL mid_first_word: got %0h expected 5a5a5", rx_data[rb % 256]);
    end
    wait_cycles(4);
  endtask

  task automatic test_violation;
    n_cmp++;
    if (dut.in_flight_r !== 4'd0) begin n_bad++; $display("FAIL viol_pre_inflight: got %0d expected 0", dut.in_flight_r); end
    force_valid = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.overflowError !== 1'b0) begin n_bad++; $display("FAIL viol_same_cycle: got %b expected 0", bus.overflowError); end
    @(posedge clk); #1;
    force_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.overflowError !== 1'b1) begin n_bad++; $display("FAIL viol_err: got %b expected 1", bus.overflowError); end
    n_cmp++;
    if (dut.in_flight_r !== 4'd0) begin n_bad++; $display("FAIL viol_inflight: got %0d expected 0", dut.in_flight_r); end
    wait_cycles(10);
    @(negedge clk);
    n_cmp++;
    if (bus.overflowError !== 1'b1) begin n_bad++; $display("FAIL viol_sticky: got %b expected 1", bus.overflowError); end
    @(posedge clk); #1;
    rst = 1'b1;
    wait_cycles(2);
    rst = 1'b0;
    force_valid = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.overflowError !== 1'b0) begin n_bad++; $display("FAIL viol_cleared: got %b expected 0", bus.overflowError); end
    @(posedge clk); #1;
    force_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.overflowError !== 1'b0 || bus.outValid !== 1'b0) begin
      n_bad++; $display("FAIL viol_drain_ignored: err %b valid %b expected 0 0", bus.overflowError, bus.outValid);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.outReady = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_toggle();
    test_reset_midflight();
    test_violation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
